exe_stage_mc: RTL and testbench
===============================

# exe_stage_mc

Parametrised multicycle execute stage for the MIPS pipeline, sitting between the ID/EX and EX/MEM pipeline registers. It generalises the execute stage in four ways: configurable datapath width, configurable forwarding-source count, registered outputs behind a valid/ready handshake, and an iterative multiply/divide unit that holds the pipeline while it runs. Branch resolution and flush generation stay in this stage.

## Interface
- XLEN, 32, datapath width; must be a power of two, at least 8
- NFWD, 2, number of forwarding sources (MEM, WB, ...)
- FSW, $clog2(NFWD+1), forwarding-select width (derived, not overridable)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  stage can accept; high only in IDLE
- exe_cmd  in  4  operation code
- val1, val2, val_src2  in  XLEN each  operand 1, operand 2/immediate, store/compare source
- br_type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- pc  in  XLEN  PC+4 of the instruction
- fwd_sel1, fwd_sel2, fwd_sel3  in  FSW each  forwarding selects for val1, val2, val_src2
- fwd_data  in  NFWD*XLEN  forwarding values; source k occupies slice [k*XLEN +: XLEN]
- out_valid  out  1  outputs below are valid this cycle
- alu_result, br_addr, st_value  out  XLEN each  result, branch target, forwarded store value
- br_taken, flush  out  1 each  branch taken; flush equals br_taken
- busy  out  1  high while a mul/div is iterating; drives the hazard-unit stall

## Operation
- Forwarding: sel 0 selects the stage's own operand; sel k in 1..NFWD selects fwd_data source k-1; any sel above NFWD selects the own operand. Forwarding is sampled only on accept, and operands are latched at that point.
- ALU operations:
  - ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111
  - SLL 1000, SRA 1001, SRL 1010; shift amount is in2[$clog2(XLEN)-1:0]
  - All arithmetic wraps modulo 2^XLEN.
  - Undefined codes produce 0.
- Mul/div (unsigned, iterative):
  - MUL 1100 returns the low product; MULHU 1101 returns the high product.
  - DIVU 1110 returns the quotient; REMU 1111 returns the remainder.
  - Divide by zero returns quotient all-ones and remainder equal to the dividend.
- Branch conditions:
  - BEZ is taken when fwd1 == 0.
  - BNE is taken when fwd1 != fwd3.
  - JMP is always taken.
  - br_addr = pc + fwd2, wrapping.
- FSM:
  - IDLE: accept on in_valid. Single-cycle ops load the output registers and stay in IDLE. Mul/div ops load the iterator and go to ITER.
  - ITER: one shift-add or restoring-subtract step per cycle for XLEN cycles, then go to DONE.
  - DONE: drive the result with out_valid for one cycle, then return to IDLE.
- Mul/div commands never branch. If br_type != 00 arrives with a mul/div command, br_taken is forced to 0.

## Timing
- Reset values: state IDLE, out_valid 0, br_taken 0, flush 0, busy 0, alu_result 0, br_addr 0, st_value 0.
- Single-cycle op accepted at edge N: out_valid, result and br_taken are valid for the cycle after N only.
- Mul/div accepted at edge N:
  - busy rises after N and stays high for XLEN+1 cycles.
  - out_valid is high in cycle N+XLEN+1, the DONE state.
  - in_ready is low from N through the DONE cycle.
- in_ready is combinational from state only. Back-to-back single-cycle ops therefore sustain one per cycle.
- out_valid is a single-cycle pulse; there is no downstream backpressure.
- flush is asserted in the same cycle as out_valid && br_taken.
- rst_n low during ITER or DONE: on the next edge the stage returns to IDLE, all outputs go to reset values, and the partial result is discarded.
- in_valid during ITER is ignored (in_ready is low). The upstream stage holds the instruction.

## Configuration
- EXE_MULDIV_EN defined: the iterator is instantiated and behaves as above.
- EXE_MULDIV_EN undefined: codes 1100–1111 behave as undefined single-cycle ops (result 0). ITER and DONE are unreachable, busy is tied to 0, and in_ready is tied to 1 after reset.

## Structure
- Package exe_pkg contains:
  - exe_cmd opcode localparams
  - br_type encodings
  - the FSM state enum (IDLE, ITER, DONE)
- Sub-module exe_muldiv_iter(XLEN) contains the multiply/divide datapath:
  - ports: start, op[1:0], a, b, done, result
  - iteration counter of width $clog2(XLEN)+1
- The forwarding mux, ALU and condition check are inline in the top module.

## Test plan
- ADD with val1=5, val2=7, all selects 0 → one cycle later out_valid=1, alu_result=12, br_taken=0.
- SUB with fwd_sel1=1, fwd_data source0=0x10, val2=3 → alu_result=0x0D. Repeat with fwd_sel1=3 (out of range for NFWD=2) → the own val1 is used.
- BNE with val1=4, val_src2 forwarded from source1=4 → br_taken=0. Same test with 5 → br_taken=1, flush=1, br_addr=pc+val2.
- MUL 0xFFFFFFFF×2 → MUL gives 0xFFFFFFFE, MULHU gives 1. Check out_valid at accept+33, busy high for 33 cycles, and in_ready low throughout.
- DIVU 7/0 → quotient 0xFFFFFFFF; REMU 7/0 → remainder 7.
- Assert rst_n=0 at cycle 10 of a DIVU → next cycle state IDLE, out_valid=0, in_ready=1, no stale result afterwards.

Source files
------------

// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the multicycle execute stage.
//   - exe_cmd operation codes (ALU and mul/div)
//   - br_type encodings
//   - FSM state enum (IDLE, ITER, DONE)
//   - is_muldiv() helper that classifies a command as iterative
package exe_pkg;

    localparam logic [3:0] CMD_ADD   = 4'b0000;
    localparam logic [3:0] CMD_SUB   = 4'b0010;
    localparam logic [3:0] CMD_AND   = 4'b0100;
    localparam logic [3:0] CMD_OR    = 4'b0101;
    localparam logic [3:0] CMD_NOR   = 4'b0110;
    localparam logic [3:0] CMD_XOR   = 4'b0111;
    localparam logic [3:0] CMD_SLL   = 4'b1000;
    localparam logic [3:0] CMD_SRA   = 4'b1001;
    localparam logic [3:0] CMD_SRL   = 4'b1010;
    localparam logic [3:0] CMD_MUL   = 4'b1100;
    localparam logic [3:0] CMD_MULHU = 4'b1101;
    localparam logic [3:0] CMD_DIVU  = 4'b1110;
    localparam logic [3:0] CMD_REMU  = 4'b1111;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } exe_state_e;

    // All four mul/div codes share the 11xx prefix.
    function automatic logic is_muldiv(input logic [3:0] cmd);
        return cmd[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/exe_muldiv_iter.sv
// exe_muldiv_iter: unsigned iterative multiply/divide datapath, one step per
// clock for XLEN clocks after start.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         load operands and begin (one-cycle pulse)
//   op[1:0]       00 MUL (low), 01 MULHU (high), 10 DIVU (quotient), 11 REMU (remainder)
//   a, b          multiplicand/multiplier or dividend/divisor
//   done          high during the cycle in which the final step is performed
//   result        selected result; valid once the final step has been taken
module exe_muldiv_iter
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    // hi/lo hold {product high, product low} for multiply and
    // {remainder, shifting dividend/quotient} for divide. m is the addend
    // (multiplicand) or the divisor.
    logic [CW-1:0]   cnt_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] hi_q, lo_q, m_q;
    logic [XLEN-1:0] hi_d, lo_d;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, m_q};
        if (op_q[1]) begin
            // Restoring step; a zero divisor always "fits", which yields an
            // all-ones quotient and leaves the dividend as remainder.
            if (div_shift >= {1'b0, m_q}) begin
                hi_d = div_diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = div_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            // Shift-add step: carry out of the add shifts into the high half.
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            op_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
        end else if (start) begin
            cnt_q <= CW'(XLEN);
            op_q  <= op;
            hi_q  <= '0;
            lo_q  <= op[1] ? a : b;
            m_q   <= op[1] ? b : a;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign done   = (cnt_q == CW'(1));
    assign result = op_q[0] ? hi_q : lo_q;

endmodule

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: multicycle MIPS execute stage between ID/EX and EX/MEM.
// Forwarding mux, ALU, branch check and registered outputs; mul/div runs on
// an iterative unit and holds the stage (busy) while it works.
// Build option: define EXE_MULDIV_EN to instantiate the mul/div iterator;
// without it codes 11xx are undefined single-cycle ops returning 0.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid / in_ready             upstream handshake
//   exe_cmd, val1, val2, val_src2   operation and operands
//   br_type, pc                     branch type and PC+4
//   fwd_sel1..3, fwd_data           forwarding selects and NFWD source values
//   out_valid                       one-cycle pulse qualifying the outputs
//   alu_result, br_addr, st_value   results
//   br_taken, flush                 branch outcome (flush mirrors br_taken)
//   busy                            mul/div in progress (stall request)
//   dbg_state                       current FSM state
// Handshake: an instruction is accepted on a rising edge where
// in_valid && in_ready; in_ready depends only on state (high in IDLE).
// out_valid is a single-cycle pulse with no backpressure.
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    localparam int FSW = $clog2(NFWD + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           exe_cmd,
    input  logic [XLEN-1:0]      val1,
    input  logic [XLEN-1:0]      val2,
    input  logic [XLEN-1:0]      val_src2,
    input  logic [1:0]           br_type,
    input  logic [XLEN-1:0]      pc,
    input  logic [FSW-1:0]       fwd_sel1,
    input  logic [FSW-1:0]       fwd_sel2,
    input  logic [FSW-1:0]       fwd_sel3,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic                 out_valid,
    output logic [XLEN-1:0]      alu_result,
    output logic [XLEN-1:0]      br_addr,
    output logic [XLEN-1:0]      st_value,
    output logic                 br_taken,
    output logic                 flush,
    output logic                 busy,
    output logic [1:0]           dbg_state
);
    localparam int SHW = $clog2(XLEN);

    // Select 0 and out-of-range selects keep the stage's own operand.
    function automatic logic [XLEN-1:0] fwd_pick(input logic [FSW-1:0] sel,
                                                 input logic [XLEN-1:0] own,
                                                 input logic [NFWD*XLEN-1:0] data);
        logic [XLEN-1:0] v;
        v = own;
        for (int k = 1; k <= NFWD; k++) begin
            if (sel == FSW'(k)) v = data[(k-1)*XLEN +: XLEN];
        end
        return v;
    endfunction

    exe_state_e      state_q, state_d;
    logic            accept, is_md, iter_done, taken, valid_q, taken_q;
    logic [XLEN-1:0] fwd1, fwd2, fwd3, alu_val, iter_result;
    logic [XLEN-1:0] alu_q, br_addr_q, st_q;

`ifdef EXE_MULDIV_EN
    assign is_md = is_muldiv(exe_cmd);

    exe_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && is_md),
        .op     (exe_cmd[1:0]),
        .a      (fwd1),
        .b      (fwd2),
        .done   (iter_done),
        .result (iter_result)
    );
`else
    assign is_md       = 1'b0;
    assign iter_done   = 1'b0;
    assign iter_result = '0;
`endif

    // Forwarding, ALU and branch condition
    always_comb begin
        fwd1 = fwd_pick(fwd_sel1, val1, fwd_data);
        fwd2 = fwd_pick(fwd_sel2, val2, fwd_data);
        fwd3 = fwd_pick(fwd_sel3, val_src2, fwd_data);

        alu_val = '0;
        case (exe_cmd)
            CMD_ADD: alu_val = fwd1 + fwd2;
            CMD_SUB: alu_val = fwd1 - fwd2;
            CMD_AND: alu_val = fwd1 & fwd2;
            CMD_OR:  alu_val = fwd1 | fwd2;
            CMD_NOR: alu_val = ~(fwd1 | fwd2);
            CMD_XOR: alu_val = fwd1 ^ fwd2;
            CMD_SLL: alu_val = fwd1 << fwd2[SHW-1:0];
            CMD_SRA: alu_val = $unsigned($signed(fwd1) >>> fwd2[SHW-1:0]);
            CMD_SRL: alu_val = fwd1 >> fwd2[SHW-1:0];
            default: alu_val = '0;
        endcase

        taken = 1'b0;
        case (br_type)
            BR_BEZ:  taken = (fwd1 == '0);
            BR_BNE:  taken = (fwd1 != fwd3);
            BR_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        if (is_md) taken = 1'b0;
    end

    // FSM next state and state-derived handshake outputs
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && is_md) state_d = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (iter_done) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            taken_q   <= 1'b0;
            alu_q     <= '0;
            br_addr_q <= '0;
            st_q      <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= accept && !is_md;
            if (accept) begin
                alu_q     <= alu_val;
                br_addr_q <= pc + fwd2;
                st_q      <= fwd3;
                taken_q   <= taken;
            end
        end
    end

    // In DONE the result comes straight from the iterator's registers.
    assign out_valid  = valid_q || (state_q == DONE);
    assign alu_result = (state_q == DONE) ? iter_result : alu_q;
    assign br_addr    = br_addr_q;
    assign st_value   = st_q;
    assign br_taken   = out_valid && taken_q;
    assign flush      = br_taken;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: randomized scoreboard bench for exe_stage_mc (XLEN=32,
// NFWD=2). Build option EXE_MULDIV_EN selects the mul/div reference behaviour.
module tb_exe_stage_mc;
    localparam int XLEN = 32;
    localparam int NFWD = 2;
`ifdef EXE_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic            clk, rst_n, in_valid, in_ready;
    logic [3:0]      exe_cmd;
    logic [31:0]     val1, val2, val_src2, pc;
    logic [1:0]      br_type, fwd_sel1, fwd_sel2, fwd_sel3;
    logic [63:0]     fwd_data;
    logic            out_valid, br_taken, flush, busy;
    logic [31:0]     alu_result, br_addr, st_value;
    logic [1:0]      dbg_state;

    exe_stage_mc #(.XLEN(XLEN), .NFWD(NFWD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .val1(val1), .val2(val2), .val_src2(val_src2),
        .br_type(br_type), .pc(pc), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .fwd_sel3(fwd_sel3), .fwd_data(fwd_data), .out_valid(out_valid),
        .alu_result(alu_result), .br_addr(br_addr), .st_value(st_value),
        .br_taken(br_taken), .flush(flush), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset bookkeeping ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    int md_lo = 1;
    int md_hi = 0;

    logic [96:0] exp_q[$];
    int          exp_t_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] own, input logic [63:0] fd);
        int k;
        k = int'(sel);
        if (k >= 1 && k <= NFWD) return fd[(k-1)*32 +: 32];
        return own;
    endfunction

    function automatic logic [96:0] model(input logic [3:0] cmd, input logic [31:0] v1, v2, v3,
                                          input logic [1:0] br, input logic [31:0] pcv,
                                          input logic [1:0] s1, s2, s3, input logic [63:0] fd);
        logic [31:0] a, b, c, r;
        logic [63:0] p;
        logic        tk, md;
        a  = pick(s1, v1, fd);
        b  = pick(s2, v2, fd);
        c  = pick(s3, v3, fd);
        p  = {32'b0, a} * {32'b0, b};
        md = MD_EN && (cmd >= 4'd12);
        case (cmd)
            4'd0:  r = a + b;
            4'd2:  r = a - b;
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = ~(a | b);
            4'd7:  r = a ^ b;
            4'd8:  r = a << b[4:0];
            4'd9:  r = $signed(a) >>> b[4:0];
            4'd10: r = a >> b[4:0];
            4'd12: r = md ? p[31:0] : 32'd0;
            4'd13: r = md ? p[63:32] : 32'd0;
            4'd14: r = !md ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd15: r = !md ? 32'd0 : (b == 0) ? a : a % b;
            default: r = 32'd0;
        endcase
        if (md)             tk = 1'b0;
        else if (br == 2'd1) tk = (a == 0);
        else if (br == 2'd2) tk = (a != c);
        else                tk = (br == 2'd3);
        return {r, pcv + b, c, tk};
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [3:0] cmd, input logic [31:0] v1, v2, v3,
                         input logic [1:0] br, input logic [31:0] pcv,
                         input logic [1:0] s1, s2, s3, input logic [63:0] fd);
        int  waited;
        bit  md;
        waited = 0;
        @(negedge clk);
        exe_cmd = cmd; val1 = v1; val2 = v2; val_src2 = v3; br_type = br; pc = pcv;
        fwd_sel1 = s1; fwd_sel2 = s2; fwd_sel3 = s3; fwd_data = fd; in_valid = 1'b1;
        // The instruction is held while the stage is busy.
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
            in_valid = 1'b0;
        end else begin
            md = MD_EN && (cmd >= 4'd12);
            exp_q.push_back(model(cmd, v1, v2, v3, br, pcv, s1, s2, s3, fd));
            exp_t_q.push_back(md ? cyc + 1 + XLEN : cyc + 1);
            if (md) begin
                md_lo = cyc + 1;
                md_hi = cyc + 1 + XLEN;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            logic [96:0] e;
            int          t;
            bit          exp_busy;
            exp_busy = (cyc >= md_lo) && (cyc <= md_hi);
            check("busy", {63'b0, busy}, {63'b0, exp_busy});
            check("in_ready", {63'b0, in_ready}, {63'b0, !exp_busy});
            check("out_valid_expected", {63'b0, out_valid}, {63'b0, exp_q.size() != 0 && exp_t_q[0] == cyc});
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                check("latency", 64'(cyc), 64'(t));
                check("alu_result", {32'b0, alu_result}, {32'b0, e[96:65]});
                check("br_addr", {32'b0, br_addr}, {32'b0, e[64:33]});
                check("st_value", {32'b0, st_value}, {32'b0, e[32:1]});
                check("br_taken", {63'b0, br_taken}, {63'b0, e[0]});
                check("flush", {63'b0, flush}, {63'b0, e[0]});
            end else if (!out_valid) begin
                check("flush_idle", {63'b0, flush}, 64'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, {62'b0, dbg_state}, 64'd0);
        check({tag, "_out_valid"}, {63'b0, out_valid}, 64'd0);
        check({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
        check({tag, "_busy"}, {63'b0, busy}, 64'd0);
        check({tag, "_br_taken"}, {63'b0, br_taken}, 64'd0);
        check({tag, "_flush"}, {63'b0, flush}, 64'd0);
        check({tag, "_alu_result"}, {32'b0, alu_result}, 64'd0);
        check({tag, "_br_addr"}, {32'b0, br_addr}, 64'd0);
        check({tag, "_st_value"}, {32'b0, st_value}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  cmd;
        logic [31:0] v1, v2, v3, pcv;
        logic [1:0]  br, s1, s2, s3;
        logic [63:0] fd;

        rst_n = 1'b0; in_valid = 1'b0; exe_cmd = '0; val1 = '0; val2 = '0; val_src2 = '0;
        br_type = '0; pc = '0; fwd_sel1 = '0; fwd_sel2 = '0; fwd_sel3 = '0; fwd_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed cases
        issue(4'b0000, 32'd5, 32'd7, 32'd0, 2'b00, 32'h100, 2'd0, 2'd0, 2'd0, 64'h0);
        issue(4'b0010, 32'h99, 32'd3, 32'd0, 2'b00, 32'h104, 2'd1, 2'd0, 2'd0, {32'h0, 32'h10});
        issue(4'b0010, 32'h20, 32'd3, 32'd0, 2'b00, 32'h108, 2'd3, 2'd0, 2'd0, {32'h0, 32'h10});
        issue(4'b0000, 32'd4, 32'h40, 32'd9, 2'b10, 32'h200, 2'd0, 2'd0, 2'd2, {32'd4, 32'd0});
        issue(4'b0000, 32'd4, 32'h40, 32'd9, 2'b10, 32'h200, 2'd0, 2'd0, 2'd2, {32'd5, 32'd0});
        issue(4'b0000, 32'd0, 32'h8, 32'd0, 2'b01, 32'h300, 2'd0, 2'd0, 2'd0, 64'h0);
        issue(4'b1001, 32'h8000_0000, 32'd4, 32'd0, 2'b11, 32'h400, 2'd0, 2'd0, 2'd0, 64'h0);
        issue(4'b1100, 32'hFFFF_FFFF, 32'd2, 32'd0, 2'b00, 32'h500, 2'd0, 2'd0, 2'd0, 64'h0);
        issue(4'b1101, 32'hFFFF_FFFF, 32'd2, 32'd0, 2'b11, 32'h504, 2'd0, 2'd0, 2'd0, 64'h0);
        issue(4'b1110, 32'd7, 32'd0, 32'd0, 2'b00, 32'h508, 2'd0, 2'd0, 2'd0, 64'h0);
        issue(4'b1111, 32'd7, 32'd0, 32'd0, 2'b01, 32'h50C, 2'd0, 2'd0, 2'd0, 64'h0);
        idle(2);

        // Randomized traffic with occasional bubbles
        for (int i = 0; i < 200; i++) begin
            cmd = 4'($urandom_range(0, 15));
            v1  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            v2  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            v3  = ($urandom_range(0, 1) == 0) ? v1 : $urandom;
            br  = 2'($urandom_range(0, 3));
            pcv = $urandom;
            s1  = 2'($urandom_range(0, 3));
            s2  = 2'($urandom_range(0, 3));
            s3  = 2'($urandom_range(0, 3));
            fd  = {$urandom, $urandom};
            if (!MD_EN && cmd >= 4'd12) br = 2'b00;
            issue(cmd, v1, v2, v3, br, pcv, s1, s2, s3, fd);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        // Reset in the middle of a divide
        issue(4'b1110, 32'd100, 32'd7, 32'd0, 2'b00, 32'h600, 2'd0, 2'd0, 2'd0, 64'h0);
        idle(10);
        rst_n = 1'b0;
        if (md_hi > cyc) md_hi = cyc;
        exp_q.delete();
        exp_t_q.delete();
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        idle(45);

        for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
